inta_cycle_sequencer: RTL and testbench
=======================================

Name: inta_cycle_sequencer

Overview:
- CPU-side interrupt acknowledge sequencer for the 8259A PIC.
- Watches interrupt_to_cpu from the control logic and generates the interrupt_acknowledge_n pulse train: 2 pulses in 8086 mode, 3 in MCS-80 mode.
- Samples the PIC data bus during each pulse and presents the captured vector or CALL address to the CPU model through a valid/accept handshake.
- Sits between the PIC top level and the bus/CPU model in system benches and in the integrated design.

Parameters:
INTA_LOW_CYCLES, 2, clocks interrupt_acknowledge_n is held low per pulse (legal range 1..15)
INTA_HIGH_CYCLES, 2, clocks interrupt_acknowledge_n is held high between and after pulses (legal range 1..15)

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset_n  input  1  synchronous, active-low reset
enable  input  1  1 = acknowledge sequences may start
u8086_mode  input  1  1 = 8086 (2 pulses), 0 = MCS-80 (3 pulses); latched at sequence start
interrupt_to_cpu  input  1  INT from the PIC; asynchronous to clock
data_bus_in  input  8  PIC data bus, sampled during pulses
interrupt_acknowledge_n  output  1  INTA to the PIC, registered, active low
busy  output  1  1 whenever state is not IDLE
result_valid  output  1  captured result available
result_accept  input  1  consumer takes result; effective only while result_valid=1
vector  output  8  8086: byte from pulse 2
call_opcode  output  8  MCS-80: byte from pulse 1 (0xCD expected)
call_address  output  16  MCS-80: {pulse-3 byte, pulse-2 byte}

Behaviour:
- Decided interface: one clock; reset is synchronous and active-low (clock, reset_n).
- Reset values (reset_n=0 at a rising edge): interrupt_acknowledge_n=1; busy=0; result_valid=0; vector=0x00; call_opcode=0x00; call_address=0x0000; synchronizer flops=0; state=IDLE.
- Reset mid-sequence: interrupt_acknowledge_n returns high on that same edge and any partial capture is discarded.
- interrupt_to_cpu passes through a 2-flop synchronizer to give irq_s.
- FSM states: IDLE, ACK_LOW, ACK_HIGH, DONE.
  - IDLE: if enable=1 and irq_s=1, go to ACK_LOW. On the transition, latch u8086_mode, set pulse_idx=0, load phase counter=INTA_LOW_CYCLES-1.
  - ACK_LOW: interrupt_acknowledge_n=0 for exactly INTA_LOW_CYCLES clocks. data_bus_in is sampled on the last ACK_LOW clock (phase counter=0) into the byte selected by pulse_idx. Then go to ACK_HIGH with counter=INTA_HIGH_CYCLES-1.
  - ACK_HIGH: interrupt_acknowledge_n=1 for exactly INTA_HIGH_CYCLES clocks. When the counter reaches 0:
    - if pulse_idx is the last pulse (1 in 8086 mode, 2 in MCS-80 mode), go to DONE;
    - otherwise increment pulse_idx and go to ACK_LOW.
  - DONE: result_valid=1. Stay until result_accept=1, then go to IDLE with result_valid=0 on the next edge. result_accept while result_valid=0 is ignored.
- Capture mapping:
  - 8086: pulse 1 data is ignored; pulse 2 → vector.
  - MCS-80: pulse 1 → call_opcode; pulse 2 → call_address[7:0]; pulse 3 → call_address[15:8].
  - Result fields not written in the current sequence keep their previous values.
- Timing:
  - interrupt_acknowledge_n is driven from a register decoded from the next state, so it is low exactly during ACK_LOW clocks.
  - Latency from interrupt_to_cpu rising (first edge sampled high) to interrupt_acknowledge_n low: 3 clocks.
  - Total sequence length: 2*(L+H) clocks in 8086 mode, 3*(L+H) in MCS-80 mode, where L=INTA_LOW_CYCLES and H=INTA_HIGH_CYCLES.
- A started sequence always completes all pulses. Pulses are never truncated by:
  - enable dropping;
  - interrupt_to_cpu dropping;
  - u8086_mode changing.
- No new sequence starts from DONE. From IDLE, a new sequence needs irq_s=1 again, so back-to-back interrupts are serviced one per handshake.
- interrupt_to_cpu pulse shorter than 1 clock: may be missed; not an error.
- Phase counters are 4 bits and never wrap. The parameter range is enforced by assertion in simulation.

Test Plan:
1. 8086, L=H=2: raise interrupt_to_cpu, PIC drives 0x00 then 0x48 → interrupt_acknowledge_n low at clocks 3-4 and 7-8; result_valid at clock 11; vector=0x48; busy high from clock 3 until the handshake.
2. MCS-80, L=H=2: bytes 0xCD, 0x20, 0x13 → 3 pulses; call_opcode=0xCD; call_address=0x1320; result_valid held 5 clocks until result_accept is asserted, then deasserts next edge.
3. u8086_mode toggled and enable dropped during pulse 1 in 8086 mode → still exactly 2 pulses; vector captured.
4. reset_n=0 during the second ACK_LOW → interrupt_acknowledge_n=1 on that edge; all outputs at reset values; no result_valid afterwards unless interrupt_to_cpu is reasserted.
5. enable=0 with interrupt_to_cpu=1 → no pulses, busy=0. Set enable=1 → first pulse on the next edge.
6. Parameters L=1, H=3, 8086 mode → pulse widths 1 clock low and 3 clocks high, checked by counting clocks; result_accept asserted before result_valid is ignored.

Source files
------------

// File: rtl/inta_cycle_sequencer.sv
// CPU-side 8259A interrupt acknowledge sequencer: issues the INTA pulse train
// (2 pulses for 8086, 3 for MCS-80) and captures the bytes the PIC drives.
module inta_cycle_sequencer #(
   parameter int INTA_LOW_CYCLES  = 2,
   parameter int INTA_HIGH_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        u8086_mode,
   input  logic        interrupt_to_cpu,
   input  logic [7:0]  data_bus_in,
   output logic        interrupt_acknowledge_n,
   output logic        busy,
   output logic        result_valid,
   input  logic        result_accept,
   output logic [7:0]  vector,
   output logic [7:0]  call_opcode,
   output logic [15:0] call_address
);

   if (INTA_LOW_CYCLES < 1 || INTA_LOW_CYCLES > 15) begin : g_bad_low
      $error("INTA_LOW_CYCLES must be in 1..15");
   end
   if (INTA_HIGH_CYCLES < 1 || INTA_HIGH_CYCLES > 15) begin : g_bad_high
      $error("INTA_HIGH_CYCLES must be in 1..15");
   end

   localparam logic [3:0] LOW_LOAD  = 4'(INTA_LOW_CYCLES - 1);
   localparam logic [3:0] HIGH_LOAD = 4'(INTA_HIGH_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACK_LOW, ACK_HIGH, DONE} state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  pidx_q, pidx_d;
   logic        mode_q, mode_d;
   logic        inta_n_q, inta_n_d;
   logic [7:0]  vector_q, vector_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [15:0] addr_q, addr_d;
   logic        last_pulse;

   assign last_pulse = mode_q ? (pidx_q == 2'd1) : (pidx_q == 2'd2);

   always_comb begin
      state_d  = state_q;
      sync1_d  = interrupt_to_cpu;
      sync2_d  = sync1_q;
      cnt_d    = cnt_q;
      pidx_d   = pidx_q;
      mode_d   = mode_q;
      vector_d = vector_q;
      opcode_d = opcode_q;
      addr_d   = addr_q;
      case (state_q)
         IDLE: begin
            if (enable && sync2_q) begin
               state_d = ACK_LOW;
               mode_d  = u8086_mode;
               pidx_d  = 2'd0;
               cnt_d   = LOW_LOAD;
            end
         end
         ACK_LOW: begin
            if (cnt_q == 4'd0) begin
               // Bus is sampled on the final low clock, when PIC data is settled.
               if (mode_q) begin
                  if (pidx_q == 2'd1) vector_d = data_bus_in;
               end else begin
                  case (pidx_q)
                     2'd0:    opcode_d     = data_bus_in;
                     2'd1:    addr_d[7:0]  = data_bus_in;
                     default: addr_d[15:8] = data_bus_in;
                  endcase
               end
               state_d = ACK_HIGH;
               cnt_d   = HIGH_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK_HIGH: begin
            if (cnt_q == 4'd0) begin
               if (last_pulse) begin
                  state_d = DONE;
               end else begin
                  state_d = ACK_LOW;
                  pidx_d  = pidx_q + 2'd1;
                  cnt_d   = LOW_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            if (result_accept) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Decoding from the next state makes the registered INTA track ACK_LOW exactly.
      inta_n_d = (state_d != ACK_LOW);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= 4'd0;
         pidx_q   <= 2'd0;
         mode_q   <= 1'b0;
         inta_n_q <= 1'b1;
         vector_q <= 8'h00;
         opcode_q <= 8'h00;
         addr_q   <= 16'h0000;
      end else begin
         state_q  <= state_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         pidx_q   <= pidx_d;
         mode_q   <= mode_d;
         inta_n_q <= inta_n_d;
         vector_q <= vector_d;
         opcode_q <= opcode_d;
         addr_q   <= addr_d;
      end
   end

   assign interrupt_acknowledge_n = inta_n_q;
   assign busy                    = (state_q != IDLE);
   assign result_valid            = (state_q == DONE);
   assign vector                  = vector_q;
   assign call_opcode             = opcode_q;
   assign call_address            = addr_q;

endmodule

// File: tb/tb_inta_cycle_sequencer.sv
// Directed bench for inta_cycle_sequencer: two instances (L=H=2 and L=1,H=3),
// a PIC byte driver, and a scoreboard of expected captured results.
module tb_inta_cycle_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a_n, rst_b_n, enable, mode, irq, accept, sel;
   logic [7:0]  dbus;
   logic        inta_a, busy_a, vld_a, inta_b, busy_b, vld_b;
   logic [7:0]  vec_a, op_a, vec_b, op_b;
   logic [15:0] addr_a, addr_b;
   logic        inta, busy, vld;
   logic [7:0]  vec, op;
   logic [15:0] addr;

   inta_cycle_sequencer #(.INTA_LOW_CYCLES(2), .INTA_HIGH_CYCLES(2)) dut_a (
      .clock(clk), .reset_n(rst_a_n), .enable(enable), .u8086_mode(mode),
      .interrupt_to_cpu(irq), .data_bus_in(dbus), .interrupt_acknowledge_n(inta_a),
      .busy(busy_a), .result_valid(vld_a), .result_accept(accept),
      .vector(vec_a), .call_opcode(op_a), .call_address(addr_a));

   inta_cycle_sequencer #(.INTA_LOW_CYCLES(1), .INTA_HIGH_CYCLES(3)) dut_b (
      .clock(clk), .reset_n(rst_b_n), .enable(enable), .u8086_mode(mode),
      .interrupt_to_cpu(irq), .data_bus_in(dbus), .interrupt_acknowledge_n(inta_b),
      .busy(busy_b), .result_valid(vld_b), .result_accept(accept),
      .vector(vec_b), .call_opcode(op_b), .call_address(addr_b));

   assign inta = sel ? inta_b : inta_a;
   assign busy = sel ? busy_b : busy_a;
   assign vld  = sel ? vld_b  : vld_a;
   assign vec  = sel ? vec_b  : vec_a;
   assign op   = sel ? op_b   : op_a;
   assign addr = sel ? addr_b : addr_a;

   typedef struct {
      logic [7:0]  vec;
      logic [7:0]  op;
      logic [15:0] addr;
   } res_t;

   res_t sb[$];
   res_t model;
   int   total = 0;
   int   bad   = 0;
   int   fw;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_inta(input logic val, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (inta !== val && n < 40);
   endtask

   // Acts as the PIC: drives one byte per INTA pulse and measures pulse widths.
   task automatic serve(input string tag, input int npulse, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2, input bit m8086,
                        input int lw, input int hw, input bit disturb, output int first_wait);
      logic [7:0] bytes [3];
      int lo, hi;
      bytes = '{b0, b1, b2};
      if (m8086) model.vec = b1;
      else begin
         model.op   = b0;
         model.addr = {b2, b1};
      end
      sb.push_back(model);
      wait_inta(1'b0, first_wait);
      chk({tag, " first low"}, 32'(inta), 32'(1'b0));
      irq = 1'b0;
      for (int p = 0; p < npulse; p++) begin
         dbus = bytes[p];
         if (disturb && p == 0) begin
            mode   = ~mode;
            enable = 1'b0;
         end
         if (p == npulse - 1) accept = 1'b0;
         lo = 0;
         while (inta === 1'b0 && lo < 20) begin
            lo++;
            @(negedge clk);
         end
         chk({tag, " low width"}, 32'(lo), 32'(lw));
         hi = 0;
         while (inta === 1'b1 && vld !== 1'b1 && hi < 20) begin
            hi++;
            @(negedge clk);
         end
         chk({tag, " high width"}, 32'(hi), 32'(hw));
      end
      chk({tag, " valid after last pulse"}, 32'(vld), 32'(1'b1));
      chk({tag, " inta high at done"}, 32'(inta), 32'(1'b1));
   endtask

   task automatic take(input string tag, input int hold);
      res_t e;
      int   n;
      n = 0;
      while (vld !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " sb nonempty"}, 32'(sb.size() != 0), 32'(1'b1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, " vector"}, 32'(vec), 32'(e.vec));
         chk({tag, " call_opcode"}, 32'(op), 32'(e.op));
         chk({tag, " call_address"}, 32'(addr), 32'(e.addr));
      end
      chk({tag, " busy in done"}, 32'(busy), 32'(1'b1));
      repeat (hold) @(negedge clk);
      chk({tag, " valid held"}, 32'(vld), 32'(1'b1));
      accept = 1'b1;
      @(negedge clk);
      accept = 1'b0;
      chk({tag, " valid cleared"}, 32'(vld), 32'(1'b0));
      chk({tag, " busy cleared"}, 32'(busy), 32'(1'b0));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " inta"}, 32'(inta), 32'(1'b1));
      chk({tag, " busy"}, 32'(busy), 32'(1'b0));
      chk({tag, " valid"}, 32'(vld), 32'(1'b0));
      chk({tag, " vector"}, 32'(vec), 32'h0);
      chk({tag, " opcode"}, 32'(op), 32'h0);
      chk({tag, " address"}, 32'(addr), 32'h0);
   endtask

   initial begin
      sel = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0; enable = 1'b1; mode = 1'b1;
      irq = 1'b0; accept = 1'b0; dbus = 8'h00;
      model = '{vec: 8'h00, op: 8'h00, addr: 16'h0000};
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_a_n = 1'b1;
      @(negedge clk);

      // 1: 8086, PIC drives 0x00 then 0x48
      irq = 1'b1;
      serve("t1", 2, 8'h00, 8'h48, 8'h00, 1'b1, 2, 2, 1'b0, fw);
      chk("t1 latency", 32'(fw), 32'd3);
      take("t1", 0);

      // 2: MCS-80 CALL 0x1320, valid held 5 clocks before accept
      mode = 1'b0;
      irq  = 1'b1;
      serve("t2", 3, 8'hCD, 8'h20, 8'h13, 1'b0, 2, 2, 1'b0, fw);
      take("t2", 4);

      // 3: mode toggled and enable dropped during pulse 1
      mode = 1'b1;
      irq  = 1'b1;
      serve("t3", 2, 8'h11, 8'h77, 8'h00, 1'b1, 2, 2, 1'b1, fw);
      take("t3", 1);
      mode   = 1'b1;
      enable = 1'b1;

      // 4: reset during the second ACK_LOW
      irq = 1'b1;
      wait_inta(1'b0, fw);
      irq  = 1'b0;
      dbus = 8'hAA;
      wait_inta(1'b1, fw);
      wait_inta(1'b0, fw);
      chk("t4 in pulse 2", 32'(inta), 32'(1'b0));
      rst_a_n = 1'b0;
      @(negedge clk);
      chk_reset("t4 reset");
      rst_a_n = 1'b1;
      model = '{vec: 8'h00, op: 8'h00, addr: 16'h0000};
      repeat (12) @(negedge clk);
      chk("t4 no valid", 32'(vld), 32'(1'b0));
      chk("t4 idle", 32'(busy), 32'(1'b0));

      // 5: enable gates the start
      enable = 1'b0;
      irq    = 1'b1;
      repeat (6) @(negedge clk);
      chk("t5 no pulse", 32'(inta), 32'(1'b1));
      chk("t5 not busy", 32'(busy), 32'(1'b0));
      enable = 1'b1;
      serve("t5", 2, 8'h01, 8'h5A, 8'h00, 1'b1, 2, 2, 1'b0, fw);
      chk("t5 latency", 32'(fw), 32'd1);
      take("t5", 0);

      // 6: L=1, H=3 instance; early accept must be ignored
      rst_a_n = 1'b0;
      sel     = 1'b1;
      model   = '{vec: 8'h00, op: 8'h00, addr: 16'h0000};
      rst_b_n = 1'b1;
      @(negedge clk);
      accept = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6 early accept valid", 32'(vld), 32'(1'b0));
      irq = 1'b1;
      serve("t6", 2, 8'h33, 8'hE4, 8'h00, 1'b1, 1, 3, 1'b0, fw);
      chk("t6 latency", 32'(fw), 32'd3);
      take("t6", 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
